fifo_word_reader: RTL and testbench



---
 rtl/fifo_word_reader.sv | 117 +++++++++++
 tb/tb_fifo_word_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_reader.sv
// Read-side consumer for the byte FIFO: packs FIFO_WIDTH-bit entries into
// WORD_BYTES-lane words and hands them downstream over a ready/valid port.
module fifo_word_reader #(
    parameter int FIFO_WIDTH = 8,
    parameter int WORD_BYTES = 4,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                             rdclk,
    input  logic                             rst_n,
    input  logic                             readReady,
    input  logic [FIFO_WIDTH-1:0]            readData,
    output logic                             readValid,
    output logic [FIFO_WIDTH*WORD_BYTES-1:0] wordData,
    output logic [WORD_BYTES-1:0]            wordKeep,
    output logic                             wordValid,
    input  logic                             wordReady,
    input  logic                             flush,
    output logic                             busy,
    output logic [CNT_W-1:0]                 wordCount
);

    localparam int WW  = FIFO_WIDTH * WORD_BYTES;
    localparam int IXW = $clog2(WORD_BYTES);
    localparam int TW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IXW-1:0] LAST_IDX = IXW'(WORD_BYTES - 1);
    localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT);

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    state_t             state_q, state_d;
    logic [IXW-1:0]     idx_q,   idx_d;
    logic [TW-1:0]      idle_q,  idle_d;
    logic [WW-1:0]      data_q,  data_d;
    logic [WORD_BYTES-1:0] keep_q, keep_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge rdclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        data_d  = data_q;
        keep_d  = keep_q;
        count_d = count_q;

        unique case (state_q)
            COLLECT: begin
                if (readReady) begin
                    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                        if (idx_q == IXW'(i)) begin
                            data_d[i*FIFO_WIDTH +: FIFO_WIDTH] = readData;
                            keep_d[i] = 1'b1;
                        end
                    end
                    idle_d = '0;
                    // A flush coinciding with a transfer keeps the new entry in the word.
                    if (idx_q == LAST_IDX || flush) begin
                        state_d = EMIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IXW'(1);
                    end
                end else if (idx_q != '0) begin
                    if (flush || (TIMEOUT != 0 && idle_q == TMAX - TW'(1))) begin
                        state_d = EMIT;
                        idx_d   = '0;
                        idle_d  = '0;
                    end else if (idle_q != TMAX) begin
                        idle_d = idle_q + TW'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            EMIT: begin
                if (wordReady) begin
                    state_d = COLLECT;
                    data_d  = '0;
                    keep_d  = '0;
                    idle_d  = '0;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // Decoded from state only so readValid never loops back through readReady.
    assign readValid = (state_q == COLLECT);
    assign wordValid = (state_q == EMIT);
    assign wordData  = data_q;
    assign wordKeep  = keep_q;
    assign wordCount = count_q;
    assign busy      = (idx_q != '0) || (state_q == EMIT);

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed vector table plus hand sequences on a TIMEOUT=16 instance, and a
// random scoreboard run on a TIMEOUT=0 instance.
module tb_fifo_word_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        readReady = 1'b0, wordReady = 1'b0, flush = 1'b0;
    logic [7:0]  readData = '0;
    logic        readValid, wordValid, busy;
    logic [31:0] wordData;
    logic [3:0]  wordKeep;
    logic [15:0] wordCount;

    logic        s_rr = 1'b0, s_wr = 1'b0, s_fl = 1'b0;
    logic [7:0]  s_rd = '0;
    logic        s_rv, s_wv, s_busy;
    logic [31:0] s_wd;
    logic [3:0]  s_wk;
    logic [15:0] s_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_word_reader #(.FIFO_WIDTH(8), .WORD_BYTES(4), .TIMEOUT(16), .CNT_W(16)) dut (
        .rdclk(clk), .rst_n(rst_n), .readReady(readReady), .readData(readData),
        .readValid(readValid), .wordData(wordData), .wordKeep(wordKeep),
        .wordValid(wordValid), .wordReady(wordReady), .flush(flush),
        .busy(busy), .wordCount(wordCount)
    );

    fifo_word_reader #(.FIFO_WIDTH(8), .WORD_BYTES(4), .TIMEOUT(0), .CNT_W(16)) dut_nt (
        .rdclk(clk), .rst_n(rst_n), .readReady(s_rr), .readData(s_rd),
        .readValid(s_rv), .wordData(s_wd), .wordKeep(s_wk),
        .wordValid(s_wv), .wordReady(s_wr), .flush(s_fl),
        .busy(s_busy), .wordCount(s_cnt)
    );

    typedef struct {
        logic        rr;
        logic [7:0]  rd;
        logic        wr;
        logic        fl;
        logic        rv;
        logic        wv;
        logic        bz;
        logic [3:0]  keep;
        logic [31:0] data;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[17];

    function automatic logic [54:0] outs();
        return {readValid, wordValid, busy, wordKeep, wordData, wordCount};
    endfunction

    function automatic logic [54:0] ex(logic rv, logic wv, logic bz, logic [3:0] k,
                                       logic [31:0] d, logic [15:0] c);
        return {rv, wv, bz, k, d, c};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic rr, logic [7:0] rd, logic wr, logic fl);
        readReady = rr;
        readData  = rd;
        wordReady = wr;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          rr  rd     wr fl   rv wv bz keep     data          cnt
        vt[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h00000011, 16'd0};
        vt[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h00002211, 16'd0};
        vt[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0111, 32'h00332211, 16'd0};
        vt[3]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h44332211, 16'd0};
        vt[4]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 16'd1};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 16'd1};
        vt[6]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h000000A1, 16'd1};
        vt[7]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0011, 32'h0000A2A1, 16'd1};
        vt[8]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 32'h00A3A2A1, 16'd1};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 16'd2};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 16'd2};
        vt[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 16'd2};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 16'd2};
        vt[13] = '{1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h000000B1, 16'd2};
        vt[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0001, 32'h000000B1, 16'd2};
        vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 32'h000000B1, 16'd2};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h00000000, 16'd3};

        #22;
        check("reset_state", outs(), ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 16'd0));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].rr, vt[i].rd, vt[i].wr, vt[i].fl);
            step();
            check($sformatf("vec%0d", i), outs(),
                  ex(vt[i].rv, vt[i].wv, vt[i].bz, vt[i].keep, vt[i].data, vt[i].cnt));
        end

        // Backpressure: full word held while wordReady is low
        drive(1'b1, 8'hC1, 1'b0, 1'b0); step();
        drive(1'b1, 8'hC2, 1'b0, 1'b0); step();
        drive(1'b1, 8'hC3, 1'b0, 1'b0); step();
        drive(1'b1, 8'hC4, 1'b0, 1'b0); step();
        check("bp_word", outs(), ex(1'b0, 1'b1, 1'b1, 4'hF, 32'hC4C3C2C1, 16'd3));
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
            step();
            check($sformatf("bp_hold%0d", i), outs(),
                  ex(1'b0, 1'b1, 1'b1, 4'hF, 32'hC4C3C2C1, 16'd3));
        end
        drive(1'b1, 8'hD1, 1'b1, 1'b0); step();
        check("bp_release", outs(), ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 16'd4));
        drive(1'b1, 8'hD1, 1'b1, 1'b0); step();
        drive(1'b1, 8'hD2, 1'b1, 1'b0); step();
        drive(1'b1, 8'hD3, 1'b1, 1'b0); step();
        drive(1'b1, 8'hD4, 1'b1, 1'b0); step();
        check("bp_next_word", outs(), ex(1'b0, 1'b1, 1'b1, 4'hF, 32'hD4D3D2D1, 16'd4));
        drive(1'b0, 8'h00, 1'b1, 1'b0); step();
        check("bp_next_accept", outs(), ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 16'd5));

        // Timeout: partial word auto-emits on the 16th idle edge
        drive(1'b1, 8'hAA, 1'b1, 1'b0); step();
        drive(1'b1, 8'hBB, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        begin
            int early = 0;
            for (int k = 1; k < 16; k++) begin
                step();
                if (wordValid !== 1'b0 || busy !== 1'b1) early++;
            end
            check("timeout_early", 64'(early), 64'd0);
        end
        step();
        check("timeout_word", outs(), ex(1'b0, 1'b1, 1'b1, 4'b0011, 32'h0000BBAA, 16'd5));
        step();
        check("timeout_accept", outs(), ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 16'd6));

        // Asynchronous reset mid-word drops the partial word
        drive(1'b1, 8'h71, 1'b1, 1'b0); step();
        drive(1'b1, 8'h72, 1'b1, 1'b0); step();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("reset_async", outs(), ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 16'd0));
        @(negedge clk) rst_n = 1'b1;
        step();
        check("reset_no_emit", outs(), ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 16'd0));
        drive(1'b1, 8'hE1, 1'b1, 1'b0); step();
        drive(1'b1, 8'hE2, 1'b1, 1'b0); step();
        drive(1'b1, 8'hE3, 1'b1, 1'b0); step();
        drive(1'b1, 8'hE4, 1'b1, 1'b0); step();
        check("reset_clean_word", outs(), ex(1'b0, 1'b1, 1'b1, 4'hF, 32'hE4E3E2E1, 16'd0));
        drive(1'b0, 8'h00, 1'b1, 1'b0); step();
        check("reset_clean_accept", outs(), ex(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 16'd1));

        // Random stress on the TIMEOUT=0 instance against an entry scoreboard
        begin
            localparam int N = 10000;
            logic [7:0]  q[$];
            logic [31:0] exp_w;
            int pushed = 0, words = 0, cyc = 0;
            bit gap_done = 0;
            while (words < N / 4 && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                if (pushed == 5002 && !gap_done) begin
                    int bad = 0;
                    s_rr = 1'b0;
                    s_wr = 1'b1;
                    repeat (100) begin
                        @(negedge clk);
                        if (s_wv !== 1'b0) bad++;
                    end
                    check("stress_no_timeout", 64'(bad), 64'd0);
                    gap_done = 1;
                end
                s_rd = 8'($urandom);
                s_rr = (pushed < N) && ($urandom_range(3) != 0);
                s_wr = 1'($urandom_range(1));
                #1;
                if (s_rr && s_rv) begin
                    q.push_back(s_rd);
                    pushed++;
                end
                if (s_wv && s_wr) begin
                    for (int l = 0; l < 4; l++)
                        exp_w[l*8 +: 8] = (q.size() > 0) ? q.pop_front() : 8'h00;
                    check($sformatf("stress_word%0d", words), {28'h0, s_wk, s_wd},
                          {28'h0, 4'hF, exp_w});
                    words++;
                end
            end
            check("stress_done", 64'(words), 64'(N / 4));
            @(negedge clk);
            check("stress_count", 64'(s_cnt), 64'(16'(words)));
            check("stress_leftover", 64'(q.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
